// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through transmit FIFO feeding the UART transmitter
// Registered empty/full/count with sticky overflow/underflow error flags.
module uart_tx_fifo #(
   parameter int DBITS     = 8,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk_100MHz,
   input  logic                 reset,
   input  logic                 wr,
   input  logic [DBITS-1:0]     wr_data,
   input  logic                 rd,
   output logic [DBITS-1:0]     rd_data,
   output logic                 empty,
   output logic                 full,
   output logic [ADDR_BITS:0]   count,
   output logic                 overflow,
   output logic                 underflow,
   input  logic                 clr_err
);

   localparam int DEPTH = 2**ADDR_BITS;
   localparam logic [ADDR_BITS:0]   DEPTH_C   = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);

   logic [DBITS-1:0]     mem_q [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   count_q, count_d;
   logic                 empty_q, empty_d;
   logic                 full_q, full_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;
   logic                 eff_wr, eff_rd;

   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign eff_wr = wr & (~full_q | rd);
   assign eff_rd = rd & ~empty_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      empty_d     = empty_q;
      full_d      = full_q;
      overflow_d  = overflow_q & ~clr_err;
      underflow_d = underflow_q & ~clr_err;

      if (eff_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (eff_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;

      if (eff_wr && !eff_rd) begin
         count_d = count_q + CNT_ONE;
         empty_d = 1'b0;
         full_d  = ((count_q + CNT_ONE) == DEPTH_C);
      end else if (eff_rd && !eff_wr) begin
         count_d = count_q - CNT_ONE;
         full_d  = 1'b0;
         empty_d = ((count_q - CNT_ONE) == '0);
      end

      // Set has priority over clr_err.
      if (wr && full_q && !rd) overflow_d = 1'b1;
      if (rd && empty_q)       underflow_d = 1'b1;
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (eff_wr) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign empty     = empty_q;
   assign full      = full_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed vector bench for uart_tx_fifo
module tb_uart_tx_fifo;

   logic       clk_100MHz = 1'b0;
   logic       reset;
   logic       wr;
   logic [7:0] wr_data;
   logic       rd;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;
   logic       clr_err;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_fifo #(.DBITS(8), .ADDR_BITS(4)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .wr         (wr),
      .wr_data    (wr_data),
      .rd         (rd),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .overflow   (overflow),
      .underflow  (underflow),
      .clr_err    (clr_err)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   typedef struct {
      logic       wr;
      logic [7:0] wd;
      logic       rd;
      logic       clr;
      logic       e_empty;
      logic       e_full;
      logic [4:0] e_count;
      logic       e_ovf;
      logic       e_udf;
      logic       chk_data;
      logic [7:0] e_data;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic e_empty, input logic e_full,
                            input logic [4:0] e_count, input logic e_ovf, input logic e_udf);
      chk({tag, ".empty"},     int'(empty),     int'(e_empty));
      chk({tag, ".full"},      int'(full),      int'(e_full));
      chk({tag, ".count"},     int'(count),     int'(e_count));
      chk({tag, ".overflow"},  int'(overflow),  int'(e_ovf));
      chk({tag, ".underflow"}, int'(underflow), int'(e_udf));
   endtask

   // Drive one cycle of inputs, let the edge pass, then release inputs.
   task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr = w; wr_data = d; rd = r; clr_err = c;
      @(posedge clk_100MHz);
      #1;
      wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
   endtask

   initial begin
      logic [7:0] model [$];
      int pushed;
      int max_cnt;
      logic [7:0] head;

      //            wr  wd     rd  clr  emp full cnt ovf udf chk data
      vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'hA5};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 8'h3C};
      vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h3C};
      vecs[6] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h11};
      vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};

      reset = 1'b1; wr = 1'b0; wr_data = 8'h00; rd = 1'b0; clr_err = 1'b0;
      repeat (2) @(posedge clk_100MHz);
      #1;
      chk_state("reset", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      reset = 1'b0;
      @(posedge clk_100MHz);
      #1;

      for (int i = 0; i < 10; i++) begin
         cycle(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
         chk_state($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full,
                   vecs[i].e_count, vecs[i].e_ovf, vecs[i].e_udf);
         if (vecs[i].chk_data) chk($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(vecs[i].e_data));
      end

      // Fill to 16, overflow attempt, drain in order.
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk_state("fill16", 1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
      cycle(1'b1, 8'h55, 1'b0, 1'b0);
      chk_state("ovf", 1'b0, 1'b1, 5'd16, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d.data", i), int'(rd_data), i);
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk_state("drained", 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", int'(overflow), 0);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'h77, 1'b1, 1'b0);
      chk_state("full_wr_rd", 1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
      chk("full_wr_rd.head", int'(rd_data), 8'h21);
      for (int i = 0; i < 16; i++) begin
         head = (i == 15) ? 8'h77 : 8'(8'h21 + i);
         chk($sformatf("drain77_%0d.data", i), int'(rd_data), int'(head));
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain77.empty", int'(empty), 1);

      // Interleaved traffic, occupancy 1..3, pointers wrap.
      pushed = 0; max_cnt = 0;
      cycle(1'b1, 8'h80, 1'b0, 1'b0); model.push_back(8'h80); pushed++;
      while (pushed < 40 || model.size() > 0) begin
         int ph;
         logic w, r;
         logic [7:0] d;
         ph = pushed % 5;
         w = (pushed < 40) && (ph != 4 || model.size() == 0) && model.size() < 3;
         r = (model.size() > 0) && (pushed >= 40 || ph >= 2);
         if (w && r && model.size() == 1 && ph == 4) w = 1'b0;
         d = 8'(8'h80 + pushed);
         if (r) chk("ilv.data", int'(rd_data), int'(model[0]));
         cycle(w, d, r, 1'b0);
         if (r) void'(model.pop_front());
         if (w) begin model.push_back(d); pushed++; end
         if (int'(count) > max_cnt) max_cnt = int'(count);
         if (int'(count) != model.size()) chk("ilv.count", int'(count), model.size());
      end
      n_checks++;
      if (max_cnt > 3) begin
         n_fail++;
         $display("FAIL ilv.max_count: got %0d, expected <= 3", max_cnt);
      end
      chk_state("ilv.end", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

      // Asynchronous reset mid-cycle with 5 words and an error flag set.
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      chk_state("pre_rst", 1'b0, 1'b0, 5'd5, 1'b0, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk_state("mid_rst", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      @(posedge clk_100MHz);
      #1 reset = 1'b0;
      cycle(1'b1, 8'h81, 1'b0, 1'b0);
      chk_state("post_rst", 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
      chk("post_rst.data", int'(rd_data), 8'h81);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
